// File: rtl/regs_frame_pkg.sv
// Shared types for the register-bank command-frame decoder:
// header default, command/state enums and the frame checksum helper.
package regs_frame_pkg;

    localparam logic [7:0] HDR_DEFAULT = 8'hA5;

    typedef enum logic [3:0] {
        CMD_WRITE = 4'd1,
        CMD_CLEAR = 4'd2,
        CMD_DIR   = 4'd3
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        GET_CA,
        GET_D,
        GET_CHK,
        SETUP,
        STROBE1,
        STROBE2,
        HOLD
    } dec_state_e;

    function automatic logic [7:0] frame_chk(input logic [7:0] ca,
                                             input logic [7:0] d);
        return ca ^ d ^ 8'hFF;
    endfunction

endpackage

// File: rtl/reg_frame_decoder_sat_counter.sv
// Saturating up-counter; holds at all-ones.
// Ports: clk_i, rst_ni (async, active-low), inc_i enable, cnt_o value.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_frame_decoder.sv
// Parses 4-byte HDR/CA/D/CHK frames from a valid/ready byte link and
// drives the register bank: data_out, one-hot sel strobes, clr_regs
// pulse and dir enables (all registered). Status: busy, frame_ok,
// err_cnt. CLK / CLR_n (async, active-low) clock and reset.
module reg_frame_decoder
    import regs_frame_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1000,
    parameter logic [7:0]  HDR     = HDR_DEFAULT
) (
    input  logic        CLK,
    input  logic        CLR_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  data_out,
    output logic [15:0] sel,
    output logic        clr_regs,
    output logic [15:0] dir,
    output logic        busy,
    output logic        frame_ok,
    output logic [7:0]  err_cnt
);

    localparam int unsigned TW =
        (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TO_LAST_I =
        (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TW-1:0] TO_LAST = TO_LAST_I[TW-1:0];

    dec_state_e    state_q;
    logic [7:0]    ca_q;
    logic [7:0]    d_q;
    logic [TW-1:0] to_q;

    cmd_e       cmd;
    logic [3:0] addr;
    logic       xfer;
    logic       in_frame;
    logic       cmd_ok;
    logic       frame_valid;
    logic       expire;
    logic       err_inc;

    assign cmd  = cmd_e'(ca_q[7:4]);
    assign addr = ca_q[3:0];

    assign rx_ready = (state_q == IDLE) || (state_q == GET_CA) ||
                      (state_q == GET_D) || (state_q == GET_CHK);
    assign busy     = (state_q != IDLE);
    assign xfer     = rx_valid && rx_ready;
    assign in_frame = (state_q == GET_CA) || (state_q == GET_D) ||
                      (state_q == GET_CHK);

    always_comb begin
        cmd_ok = 1'b0;
        case (cmd)
            CMD_WRITE: cmd_ok = 1'b1;
            CMD_CLEAR: cmd_ok = 1'b1;
            CMD_DIR:   cmd_ok = (addr[3:1] == 3'd0);
            default:   cmd_ok = 1'b0;
        endcase
    end

    assign frame_valid = cmd_ok && (rx_data == frame_chk(ca_q, d_q));

    // A transfer in the expiry cycle takes priority over abandoning.
    assign expire  = (TIMEOUT != 0) && in_frame && !xfer &&
                     (to_q == TO_LAST);
    assign err_inc = expire ||
                     ((state_q == GET_CHK) && xfer && !frame_valid);

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state_q  <= IDLE;
            ca_q     <= '0;
            d_q      <= '0;
            to_q     <= '0;
            data_out <= '0;
            sel      <= '0;
            clr_regs <= 1'b0;
            dir      <= '0;
            frame_ok <= 1'b0;
        end else begin
            frame_ok <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (xfer && (rx_data == HDR)) begin
                        to_q    <= '0;
                        state_q <= GET_CA;
                    end
                end
                GET_CA, GET_D: begin
                    if (xfer) begin
                        to_q <= '0;
                        if (state_q == GET_CA) begin
                            ca_q    <= rx_data;
                            state_q <= GET_D;
                        end else begin
                            d_q     <= rx_data;
                            state_q <= GET_CHK;
                        end
                    end else if (expire) begin
                        state_q <= IDLE;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                GET_CHK: begin
                    if (xfer) begin
                        to_q <= '0;
                        if (!frame_valid) begin
                            state_q <= IDLE;
                        end else if (cmd == CMD_DIR) begin
                            frame_ok <= 1'b1;
                            state_q  <= IDLE;
                            if (addr[0]) begin
                                dir[15:8] <= d_q;
                            end else begin
                                dir[7:0] <= d_q;
                            end
                        end else begin
                            frame_ok <= 1'b1;
                            state_q  <= SETUP;
                            if (cmd == CMD_WRITE) begin
                                data_out <= d_q;
                            end
                        end
                    end else if (expire) begin
                        state_q <= IDLE;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                SETUP: begin
                    if (cmd == CMD_WRITE) begin
                        sel <= 16'h0001 << addr;
                    end else begin
                        clr_regs <= 1'b1;
                    end
                    state_q <= STROBE1;
                end
                STROBE1: begin
                    state_q <= STROBE2;
                end
                STROBE2: begin
                    sel      <= '0;
                    clr_regs <= 1'b0;
                    state_q  <= HOLD;
                end
                HOLD: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    sat_counter #(
        .W (8)
    ) u_err_cnt (
        .clk_i  (CLK),
        .rst_ni (CLR_n),
        .inc_i  (err_inc),
        .cnt_o  (err_cnt)
    );

endmodule

// File: tb/tb_reg_frame_decoder.sv
// Scoreboard bench for reg_frame_decoder: a frame-level model predicts
// strobes, dir/err changes and frame_ok; a negedge monitor compares.
`timescale 1ns/1ps
module tb_reg_frame_decoder;

    localparam int         TO = 5;
    localparam logic [7:0] H  = 8'hA5;

    logic        CLK = 1'b0;
    logic        CLR_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  data_out;
    logic [15:0] sel;
    logic        clr_regs;
    logic [15:0] dir;
    logic        busy;
    logic        frame_ok;
    logic [7:0]  err_cnt;

    reg_frame_decoder #(
        .TIMEOUT (TO),
        .HDR     (H)
    ) dut (
        .CLK      (CLK),
        .CLR_n    (CLR_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .data_out (data_out),
        .sel      (sel),
        .clr_regs (clr_regs),
        .dir      (dir),
        .busy     (busy),
        .frame_ok (frame_ok),
        .err_cnt  (err_cnt)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(input string nm, input logic [31:0] a,
                                input logic [31:0] x);
        n_chk++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, a, x);
        end
    endfunction

    // Expected-event queues filled by the model, drained by the monitor.
    logic [23:0] q_ok[$];
    logic [23:0] q_sel[$];
    logic [23:0] q_clr[$];
    logic [7:0]  q_err[$];
    logic [15:0] q_dir[$];

    // Frame-level reference model.
    int          pos = 0;
    logic [7:0]  m_ca = 8'h00;
    logic [7:0]  m_d = 8'h00;
    logic [7:0]  m_data = 8'h00;
    logic [7:0]  m_err = 8'h00;
    logic [15:0] m_dir = 16'h0000;

    function automatic logic [7:0] fchk(input logic [7:0] ca,
                                        input logic [7:0] d);
        return ca ^ d ^ 8'hFF;
    endfunction

    function automatic int rgap();
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 10) return 0;
        return r - 9;
    endfunction

    task automatic err_bump();
        if (m_err != 8'hFF) begin
            m_err = m_err + 8'd1;
            q_err.push_back(m_err);
        end
    endtask

    task automatic model_gap(input int g);
        if (pos != 0 && g >= TO) begin
            err_bump();
            pos = 0;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [3:0]  c;
        logic [3:0]  a;
        logic        good;
        logic [15:0] nd;
        case (pos)
            0: if (b == H) pos = 1;
            1: begin m_ca = b; pos = 2; end
            2: begin m_d = b; pos = 3; end
            default: begin
                pos = 0;
                c = m_ca[7:4];
                a = m_ca[3:0];
                good = (b == fchk(m_ca, m_d)) &&
                       (c == 4'd1 || c == 4'd2 || (c == 4'd3 && a < 4'd2));
                if (!good) begin
                    err_bump();
                end else begin
                    if (c == 4'd1) m_data = m_d;
                    if (c == 4'd3) begin
                        nd = m_dir;
                        if (a == 4'd0) nd[7:0] = m_d;
                        else nd[15:8] = m_d;
                        if (nd != m_dir) q_dir.push_back(nd);
                        m_dir = nd;
                    end
                    q_ok.push_back({m_dir, m_data});
                    if (c == 4'd1) q_sel.push_back({16'h0001 << a, m_d});
                    if (c == 4'd2) q_clr.push_back({m_dir, m_data});
                end
            end
        endcase
    endtask

    // Driver: called and returns at 1 ns after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int g);
        int n;
        model_gap(g);
        rx_valid = 1'b0;
        if (g > 0) begin
            repeat (g) @(posedge CLK);
            #1;
        end
        model_byte(b);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (n >= 50) begin
            n_chk++;
            n_fail++;
            $display("FAIL ready_wait: rx_ready=0 for %0d cycles, need 1", n);
        end
        @(posedge CLK);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] ca, input logic [7:0] d,
                              input logic [7:0] c, input bit rnd);
        send_byte(H, rnd ? rgap() : 0);
        send_byte(ca, rnd ? rgap() : 0);
        send_byte(d, rnd ? rgap() : 0);
        send_byte(c, rnd ? rgap() : 0);
    endtask

    // Monitor.
    logic [15:0] p_sel = 16'h0;
    logic [15:0] p_dir = 16'h0;
    logic [15:0] s_exp = 16'h0;
    logic        p_clr = 1'b0;
    logic [7:0]  p_err = 8'h0;
    logic [7:0]  p_data = 8'h0;
    logic [7:0]  h_data = 8'h0;
    logic [23:0] c_exp = 24'h0;
    logic [23:0] e;
    int          sel_w = 0;
    int          clr_w = 0;
    int          rdy_low = 0;

    always @(negedge CLK) begin
        if (!CLR_n) begin
            p_sel = '0; p_dir = '0; p_clr = 1'b0;
            p_err = '0; p_data = '0;
            sel_w = 0; clr_w = 0; rdy_low = 0;
        end else begin
            if (frame_ok) begin
                if (q_ok.size() == 0) chk("frame_ok_extra", frame_ok, 0);
                else begin
                    e = q_ok.pop_front();
                    chk("ok_data", data_out, e[7:0]);
                    chk("ok_dir", dir, e[23:8]);
                end
            end
            if (sel != 0 && p_sel == 0) begin
                if (q_sel.size() == 0) chk("sel_extra", sel, 0);
                else begin
                    e = q_sel.pop_front();
                    s_exp = e[23:8];
                    h_data = e[7:0];
                    chk("sel_value", sel, s_exp);
                    chk("sel_setup", p_data, h_data);
                end
                sel_w = 1;
            end else if (sel != 0) begin
                sel_w++;
                chk("sel_stable", sel, s_exp);
                chk("sel_data", data_out, h_data);
            end else if (p_sel != 0) begin
                chk("sel_width", sel_w, 2);
                chk("sel_hold", data_out, h_data);
            end
            if (clr_regs && !p_clr) begin
                if (q_clr.size() == 0) chk("clr_extra", clr_regs, 0);
                else begin
                    c_exp = q_clr.pop_front();
                    chk("clr_data", data_out, c_exp[7:0]);
                    chk("clr_dir", dir, c_exp[23:8]);
                end
                clr_w = 1;
            end else if (clr_regs) begin
                clr_w++;
            end else if (p_clr) begin
                chk("clr_width", clr_w, 2);
                chk("clr_keep_data", data_out, c_exp[7:0]);
                chk("clr_keep_dir", dir, c_exp[23:8]);
            end
            if (err_cnt != p_err) begin
                if (q_err.size() == 0) chk("err_extra", err_cnt, m_err);
                else chk("err_cnt", err_cnt, q_err.pop_front());
            end
            if (dir != p_dir) begin
                if (q_dir.size() == 0) chk("dir_extra", dir, m_dir);
                else chk("dir", dir, q_dir.pop_front());
            end
            if (!rx_ready) begin
                rdy_low++;
                chk("busy_when_stalled", busy, 1);
            end else if (rdy_low != 0) begin
                chk("stall_len", rdy_low, 4);
                rdy_low = 0;
            end
            p_sel = sel; p_dir = dir; p_clr = clr_regs;
            p_err = err_cnt; p_data = data_out;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, need finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] ca;
        logic [7:0] d;
        int k;

        #3;
        chk("rst_async_sel", sel, 0);
        chk("rst_async_dir", dir, 0);
        repeat (2) @(posedge CLK);
        #1;
        CLR_n = 1'b1;
        @(posedge CLK);
        #1;
        chk("rst_ready", rx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_clr", clr_regs, 0);
        chk("rst_data", data_out, 0);
        chk("rst_ok", frame_ok, 0);

        // WRITE A5 13 5A B6
        send_frame(8'h13, 8'h5A, 8'hB6, 0);
        chk("wr_data", data_out, 8'h5A);
        chk("wr_ok", frame_ok, 1);
        @(posedge CLK);
        #1;
        chk("wr_sel_rise", sel, 16'h0008);
        chk("wr_err", err_cnt, 0);

        // DIR low then high byte
        send_frame(8'h30, 8'hC3, 8'h0C, 0);
        chk("dir_lo", dir, 16'h00C3);
        send_frame(8'h31, 8'h81, fchk(8'h31, 8'h81), 0);
        chk("dir_full", dir, 16'h81C3);
        chk("dir_ready", rx_ready, 1);

        // Bad checksum, then noise
        send_frame(8'h13, 8'h5A, 8'hB7, 0);
        chk("badchk_err", err_cnt, 1);
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        chk("noise_err", err_cnt, 1);

        // CLEAR then invalid command
        send_frame(8'h20, 8'h00, 8'hDF, 0);
        repeat (6) @(posedge CLK);
        #1;
        chk("clear_data", data_out, 8'h5A);
        chk("clear_dir", dir, 16'h81C3);
        send_frame(8'h70, 8'h00, 8'h8F, 0);
        chk("badcmd_err", err_cnt, 2);

        // Timeout after CA; trailing byte lands in IDLE
        send_byte(H, 0);
        send_byte(8'h13, 0);
        send_byte(8'h5A, TO);
        chk("to_err", err_cnt, 3);
        chk("to_idle", busy, 0);

        // Byte in the expiry cycle is accepted
        send_byte(H, 0);
        send_byte(8'h14, 0);
        send_byte(8'h3C, TO - 1);
        send_byte(fchk(8'h14, 8'h3C), 0);
        chk("expiry_ok", frame_ok, 1);
        chk("expiry_data", data_out, 8'h3C);
        chk("expiry_err", err_cnt, 3);
        repeat (5) @(posedge CLK);
        #1;

        // Reset during STROBE1
        send_frame(8'h13, 8'h5A, 8'hB6, 0);
        @(posedge CLK);
        #1;
        chk("mid_strobe_sel", sel, 16'h0008);
        CLR_n = 1'b0;
        #1;
        chk("arst_sel", sel, 0);
        chk("arst_dir", dir, 0);
        chk("arst_err", err_cnt, 0);
        chk("arst_clr", clr_regs, 0);
        chk("arst_ready", rx_ready, 1);
        q_ok.delete(); q_sel.delete(); q_clr.delete();
        q_err.delete(); q_dir.delete();
        pos = 0; m_err = 0; m_dir = 0; m_data = 0;
        @(posedge CLK);
        #1;
        CLR_n = 1'b1;
        send_frame(8'h1F, 8'h77, fchk(8'h1F, 8'h77), 0);
        chk("post_rst_data", data_out, 8'h77);
        repeat (5) @(posedge CLK);
        #1;

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            k = int'($urandom_range(0, 7));
            d = 8'($urandom_range(0, 255));
            case (k)
                0, 1: begin
                    ca = {4'd1, 4'($urandom_range(0, 15))};
                    send_frame(ca, d, fchk(ca, d), 1);
                end
                2: begin
                    ca = {4'd2, 4'($urandom_range(0, 15))};
                    send_frame(ca, d, fchk(ca, d), 1);
                end
                3: begin
                    ca = {4'd3, 4'($urandom_range(0, 1))};
                    send_frame(ca, d, fchk(ca, d), 1);
                end
                4: begin
                    ca = 8'($urandom_range(0, 255));
                    send_frame(ca, d,
                               fchk(ca, d) ^ 8'($urandom_range(1, 255)), 1);
                end
                5: begin
                    if ($urandom_range(0, 1) == 0)
                        ca = {4'($urandom_range(4, 15)),
                              4'($urandom_range(0, 15))};
                    else
                        ca = {4'd3, 4'($urandom_range(2, 15))};
                    send_frame(ca, d, fchk(ca, d), 1);
                end
                6: send_byte(d, rgap());
                default: begin
                    ca = {4'd1, 4'($urandom_range(0, 15))};
                    send_frame(ca, H, fchk(ca, H), 1);
                end
            endcase
        end
        repeat (6) @(posedge CLK);
        #1;

        // Saturation
        for (int i = 0; i < 260; i++) begin
            send_frame(8'h13, 8'h5A, 8'hB7, 0);
        end
        chk("sat_err", err_cnt, 8'hFF);

        repeat (20) @(posedge CLK);
        #1;
        chk("q_ok_drained", q_ok.size(), 0);
        chk("q_sel_drained", q_sel.size(), 0);
        chk("q_clr_drained", q_clr.size(), 0);
        chk("q_err_drained", q_err.size(), 0);
        chk("q_dir_drained", q_dir.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
